rename_regfile: RTL and testbench
=================================

Name: rename_regfile

Overview:
- Parametrised architectural register file with per-register rename status (busy bit plus ROB tag) for the out-of-order core.
- Serves NUM_RD combinational operand lookups to the decoder.
- Accepts one rename per cycle from the decoder and NUM_CMT in-order commits per cycle from the ROB.
- Clears all rename state on rollback; exports a registered count of busy registers to dispatch for throttling.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is hardwired zero.
- DATA_W, 32, register data width.
- ROB_ID_W, 4, ROB tag width.
- NUM_RD, 2, number of operand read ports.
- NUM_CMT, 2, number of commit ports; port 0 is always the oldest.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- rdy  in  1  global enable; all state frozen when low.
- rollback  in  1  flush all rename state.
- rd_idx  in  NUM_RD*$clog2(REG_NUM)  packed source register indices.
- rd_busy  out  NUM_RD  operand pending.
- rd_data  out  NUM_RD*DATA_W  operand value.
- rd_tag  out  NUM_RD*ROB_ID_W  producing ROB tag; 0 when not busy.
- ren_valid  in  1  rename request.
- ren_rd  in  $clog2(REG_NUM)  destination register.
- ren_tag  in  ROB_ID_W  new producer tag.
- cmt_valid  in  NUM_CMT  commit valid per port.
- cmt_rd  in  NUM_CMT*$clog2(REG_NUM)  commit destinations.
- cmt_data  in  NUM_CMT*DATA_W  commit values.
- cmt_tag  in  NUM_CMT*ROB_ID_W  committing ROB tags.
- busy_cnt  out  $clog2(REG_NUM+1)  registered number of busy registers.

Behaviour:
- Reset, asynchronous on rst rising or high: all data, tags and busy bits 0; busy_cnt 0. Read outputs are therefore 0. Reset mid-operation discards everything immediately.
- rdy low: no state update. Reads still answer combinationally.
- Reads are combinational, zero latency, and reflect state before the current edge. A same-cycle rename is not visible; the decoder resolves intra-cycle rename.
- Register 0 always reads busy=0, data=0, tag=0. Rename, commit and bypass targeting register 0 are ignored.
- Commit, per valid port k with cmt_rd!=0:
  - Write data unconditionally.
  - Clear busy and zero the tag only if busy[rd] and tag[rd]==cmt_tag[k].
- Two commit ports, same rd, same cycle: the higher-index (younger) port's data wins. Busy is cleared if either port's tag matches.
- Rename, when ren_valid and ren_rd!=0: set busy, load tag. Rename beats a same-cycle commit clear on the same register; the commit data is still written.
- Rollback: clears all busy bits and tags. It beats a same-cycle rename. Same-cycle commit data is still written.
- busy_cnt is updated each enabled edge to the popcount of the next-state busy vector, so it equals popcount(busy) one cycle after any change.
- Tag wrap-around is handled by the ROB. Tag 0 is a legal tag; busy alone qualifies validity.

Optional Feature:
- Macro: RF_CMT_BYPASS_EN.
- Defined: a read whose register is busy, with a valid commit port this cycle matching both rd and current tag, returns busy=0, the commit data and tag=0. The highest-index matching port wins.
- Undefined: reads return stored state only. The decoder must snoop the ROB broadcast for same-cycle commits.

Decomposition:
- Package rf_pkg holds:
  - width localparams (REG_IDX_W=$clog2(REG_NUM), BUSY_CNT_W);
  - a struct typedef for the per-register status {busy, tag};
  - the REG_ZERO constant.
- One natural sub-module, rf_read_port, instantiated NUM_RD times: index mux plus the optional bypass priority mux.

Test Plan:
- Reset, read ports 1 and 5 -> busy=0, data=0, tag=0, busy_cnt=0.
- Rename r5 with tag 3. Next cycle read r5 -> busy=1, tag=3, busy_cnt=1. Commit r5 with tag 3, data 0xDEADBEEF. Next cycle read -> busy=0, data=0xDEADBEEF, busy_cnt=0.
- Rename r7 with tag 2, then rename r7 with tag 6, then commit r7 with tag 2, data 0x11 -> data=0x11, busy=1, tag=6 (stale commit does not clear).
- Same cycle: commit r9 tag 4 on port 0 with data 0xA, rename r9 tag 8 -> data=0xA, busy=1, tag=8. Same cycle: port 0 commits r3 with 0x1 and port 1 commits r3 with 0x2 -> data=0x2.
- Rename r1, r2, r3, then rollback together with a rename of r4 and a commit of r2 with data 0x55 -> all not busy, busy_cnt=0, r2=0x55. Rename/commit of r0 -> r0 stays 0 and not busy.
- With RF_CMT_BYPASS_EN: r10 busy with tag 5, commit r10 tag 5 data 0x77 while reading r10 -> busy=0, data=0x77 in the same cycle. Without the macro -> busy=1, tag=5. Also assert rst during active commits -> all outputs 0 immediately.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, per-register rename status and the hardwired-zero index
// for the architectural register file.
package rf_pkg;

  localparam int RF_REG_NUM  = 32;
  localparam int RF_ROB_ID_W = 4;
  localparam int REG_IDX_W   = $clog2(RF_REG_NUM);
  localparam int BUSY_CNT_W  = $clog2(RF_REG_NUM + 1);

  // The tag field width follows RF_ROB_ID_W, so the top's ROB_ID_W must match it.
  typedef struct packed {
    logic                   busy;
    logic [RF_ROB_ID_W-1:0] tag;
  } rf_status_t;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational operand lookup. With RF_CMT_BYPASS_EN defined, a same-cycle
// commit that retires the current producer is forwarded to the reader.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4,
  parameter int NUM_CMT  = 2
) (
  input  logic [$clog2(REG_NUM)-1:0]         idx,
  input  logic [REG_NUM-1:0]                 busy_vec,
  input  logic [REG_NUM*DATA_W-1:0]          data_flat,
  input  logic [REG_NUM*ROB_ID_W-1:0]        tag_flat,
`ifdef RF_CMT_BYPASS_EN
  input  logic [NUM_CMT-1:0]                 cmt_valid,
  input  logic [NUM_CMT*$clog2(REG_NUM)-1:0] cmt_rd,
  input  logic [NUM_CMT*DATA_W-1:0]          cmt_data,
  input  logic [NUM_CMT*ROB_ID_W-1:0]        cmt_tag,
`endif
  output logic                               busy,
  output logic [DATA_W-1:0]                  data,
  output logic [ROB_ID_W-1:0]                tag
);

  localparam int IDX_W = $clog2(REG_NUM);

  logic                st_busy;
  logic [DATA_W-1:0]   st_data;
  logic [ROB_ID_W-1:0] st_tag;

  always_comb begin
    st_busy = 1'b0;
    st_data = '0;
    st_tag  = '0;
    if (idx != REG_ZERO) begin
      st_busy = busy_vec[idx];
      st_data = data_flat[int'(idx)*DATA_W +: DATA_W];
      st_tag  = tag_flat[int'(idx)*ROB_ID_W +: ROB_ID_W];
    end
    busy = st_busy;
    data = st_data;
    tag  = st_tag;
`ifdef RF_CMT_BYPASS_EN
    // Ascending scan so the highest-index (youngest) matching port wins.
    if (st_busy) begin
      for (int k = 0; k < NUM_CMT; k++) begin
        if (cmt_valid[k] && cmt_rd[k*IDX_W +: IDX_W] == idx &&
            cmt_tag[k*ROB_ID_W +: ROB_ID_W] == st_tag) begin
          busy = 1'b0;
          data = cmt_data[k*DATA_W +: DATA_W];
          tag  = '0;
        end
      end
    end
`endif
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy/ROB-tag rename status.
// Optional same-cycle commit bypass on reads: define RF_CMT_BYPASS_EN.
module rename_regfile
  import rf_pkg::*;
#(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4,
  parameter int NUM_RD   = 2,
  parameter int NUM_CMT  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rdy,
  input  logic                               rollback,
  input  logic [NUM_RD*$clog2(REG_NUM)-1:0]  rd_idx,
  output logic [NUM_RD-1:0]                  rd_busy,
  output logic [NUM_RD*DATA_W-1:0]           rd_data,
  output logic [NUM_RD*ROB_ID_W-1:0]         rd_tag,
  input  logic                               ren_valid,
  input  logic [$clog2(REG_NUM)-1:0]         ren_rd,
  input  logic [ROB_ID_W-1:0]                ren_tag,
  input  logic [NUM_CMT-1:0]                 cmt_valid,
  input  logic [NUM_CMT*$clog2(REG_NUM)-1:0] cmt_rd,
  input  logic [NUM_CMT*DATA_W-1:0]          cmt_data,
  input  logic [NUM_CMT*ROB_ID_W-1:0]        cmt_tag,
  output logic [$clog2(REG_NUM+1)-1:0]       busy_cnt
);

  localparam int IDX_W = $clog2(REG_NUM);
  localparam int CNT_W = $clog2(REG_NUM + 1);

  rf_status_t        stat_q [REG_NUM];
  rf_status_t        stat_d [REG_NUM];
  logic [DATA_W-1:0] data_q [REG_NUM];
  logic [DATA_W-1:0] data_d [REG_NUM];
  logic [CNT_W-1:0]  cnt_d;
  logic [IDX_W-1:0]  c_rd;

  logic [REG_NUM-1:0]          busy_vec;
  logic [REG_NUM*DATA_W-1:0]   data_flat;
  logic [REG_NUM*ROB_ID_W-1:0] tag_flat;

  always_comb begin
    c_rd = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      data_d[r] = data_q[r];
      stat_d[r] = stat_q[r];
    end
    // Later ports overwrite earlier ones, so the younger commit's data lands;
    // the clear test uses pre-edge status so either matching port retires it.
    for (int k = 0; k < NUM_CMT; k++) begin
      c_rd = cmt_rd[k*IDX_W +: IDX_W];
      if (cmt_valid[k] && c_rd != REG_ZERO) begin
        data_d[c_rd] = cmt_data[k*DATA_W +: DATA_W];
        if (stat_q[c_rd].busy && stat_q[c_rd].tag == cmt_tag[k*ROB_ID_W +: ROB_ID_W])
          stat_d[c_rd] = '0;
      end
    end
    if (rollback) begin
      for (int r = 0; r < REG_NUM; r++) stat_d[r] = '0;
    end else if (ren_valid && ren_rd != REG_ZERO) begin
      stat_d[ren_rd] = '{busy: 1'b1, tag: ren_tag};
    end
    cnt_d = '0;
    for (int r = 0; r < REG_NUM; r++) cnt_d = cnt_d + CNT_W'(stat_d[r].busy);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        data_q[r] <= '0;
        stat_q[r] <= '0;
      end
      busy_cnt <= '0;
    end else if (rdy) begin
      for (int r = 0; r < REG_NUM; r++) begin
        data_q[r] <= data_d[r];
        stat_q[r] <= stat_d[r];
      end
      busy_cnt <= cnt_d;
    end
  end

  for (genvar r = 0; r < REG_NUM; r++) begin : g_flat
    assign busy_vec[r]                         = stat_q[r].busy;
    assign data_flat[r*DATA_W +: DATA_W]       = data_q[r];
    assign tag_flat[r*ROB_ID_W +: ROB_ID_W]    = stat_q[r].tag;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .REG_NUM  (REG_NUM),
      .DATA_W   (DATA_W),
      .ROB_ID_W (ROB_ID_W),
      .NUM_CMT  (NUM_CMT)
    ) u_rd (
      .idx       (rd_idx[p*IDX_W +: IDX_W]),
      .busy_vec  (busy_vec),
      .data_flat (data_flat),
      .tag_flat  (tag_flat),
`ifdef RF_CMT_BYPASS_EN
      .cmt_valid (cmt_valid),
      .cmt_rd    (cmt_rd),
      .cmt_data  (cmt_data),
      .cmt_tag   (cmt_tag),
`endif
      .busy      (rd_busy[p]),
      .data      (rd_data[p*DATA_W +: DATA_W]),
      .tag       (rd_tag[p*ROB_ID_W +: ROB_ID_W])
    );
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios plus a randomized
// run against an array-based reference model.
module tb_rename_regfile;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic [9:0]  rd_idx;
  logic [1:0]  rd_busy;
  logic [63:0] rd_data;
  logic [7:0]  rd_tag;
  logic        ren_valid;
  logic [4:0]  ren_rd;
  logic [3:0]  ren_tag;
  logic [1:0]  cmt_valid;
  logic [9:0]  cmt_rd;
  logic [63:0] cmt_data;
  logic [7:0]  cmt_tag;
  logic [5:0]  busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_data [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  rename_regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .rd_idx(rd_idx), .rd_busy(rd_busy), .rd_data(rd_data), .rd_tag(rd_tag),
    .ren_valid(ren_valid), .ren_rd(ren_rd), .ren_tag(ren_tag),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_data(cmt_data), .cmt_tag(cmt_tag),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
    end
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  // Applies one clock edge of the architectural rules to the model.
  function automatic void model_step();
    logic       nb [32];
    logic [3:0] nt [32];
    logic [4:0] r;
    if (rst || !rdy) return;
    for (int i = 0; i < 32; i++) begin nb[i] = m_busy[i]; nt[i] = m_tag[i]; end
    for (int k = 0; k < 2; k++) begin
      r = cmt_rd[k*5 +: 5];
      if (cmt_valid[k] && r != 0) begin
        m_data[r] = cmt_data[k*32 +: 32];
        if (m_busy[r] && m_tag[r] == cmt_tag[k*4 +: 4]) begin nb[r] = 1'b0; nt[r] = '0; end
      end
    end
    if (rollback) begin
      for (int i = 0; i < 32; i++) begin nb[i] = 1'b0; nt[i] = '0; end
    end else if (ren_valid && ren_rd != 0) begin
      nb[ren_rd] = 1'b1; nt[ren_rd] = ren_tag;
    end
    for (int i = 0; i < 32; i++) begin m_busy[i] = nb[i]; m_tag[i] = nt[i]; end
  endfunction

  function automatic void exp_read(input logic [4:0] idx, output logic b,
                                   output logic [31:0] d, output logic [3:0] t);
    b = 1'b0; d = '0; t = '0;
    if (idx != 0) begin
      b = m_busy[idx]; d = m_data[idx]; t = m_tag[idx];
`ifdef RF_CMT_BYPASS_EN
      if (m_busy[idx])
        for (int k = 0; k < 2; k++)
          if (cmt_valid[k] && cmt_rd[k*5 +: 5] == idx && cmt_tag[k*4 +: 4] == m_tag[idx]) begin
            b = 1'b0; d = cmt_data[k*32 +: 32]; t = '0;
          end
`endif
    end
  endfunction

  task automatic clr_in();
    rollback = 1'b0; ren_valid = 1'b0; ren_rd = '0; ren_tag = '0;
    cmt_valid = '0; cmt_rd = '0; cmt_data = '0; cmt_tag = '0;
  endtask

  task automatic set_cmt(input int k, input logic [4:0] r, input logic [3:0] t,
                         input logic [31:0] d);
    cmt_valid[k] = 1'b1; cmt_rd[k*5 +: 5] = r; cmt_tag[k*4 +: 4] = t; cmt_data[k*32 +: 32] = d;
  endtask

  task automatic set_ren(input logic [4:0] r, input logic [3:0] t);
    ren_valid = 1'b1; ren_rd = r; ren_tag = t;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clr_in(); model_reset();
    rd_idx = {5'd5, 5'd1};
    #3;
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %b want 00", rd_busy); end
    n_cmp++; if (rd_data !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", rd_data); end
    n_cmp++; if (rd_tag !== 8'h0) begin n_err++; $display("FAIL reset_tag: got %h want 0", rd_tag); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_rename_commit();
    clr_in(); set_ren(5, 3); tick(); clr_in();
    rd_idx = {5'd0, 5'd5}; #1;
    n_cmp++; if (rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd3)
      begin n_err++; $display("FAIL ren_r5: got busy=%b tag=%0d want busy=1 tag=3", rd_busy[0], rd_tag[3:0]); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL ren_cnt: got %0d want 1", busy_cnt); end
    set_cmt(0, 5, 3, 32'hDEADBEEF); tick(); clr_in();
    n_cmp++; if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'hDEADBEEF || rd_tag[3:0] !== 4'd0)
      begin n_err++; $display("FAIL cmt_r5: got busy=%b data=%h tag=%0d want 0/deadbeef/0", rd_busy[0], rd_data[31:0], rd_tag[3:0]); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL cmt_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_stale_commit();
    clr_in(); set_ren(7, 2); tick(); set_ren(7, 6); tick(); clr_in();
    set_cmt(0, 7, 2, 32'h11); tick(); clr_in();
    rd_idx = {5'd0, 5'd7}; #1;
    n_cmp++; if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h11 || rd_tag[3:0] !== 4'd6)
      begin n_err++; $display("FAIL stale_r7: got busy=%b data=%h tag=%0d want 1/11/6", rd_busy[0], rd_data[31:0], rd_tag[3:0]); end
  endtask

  task automatic test_same_cycle();
    clr_in(); set_ren(9, 4); tick(); clr_in();
    set_cmt(0, 9, 4, 32'hA); set_ren(9, 8); tick(); clr_in();
    rd_idx = {5'd9, 5'd9}; #1;
    n_cmp++; if (rd_busy[1] !== 1'b1 || rd_data[63:32] !== 32'hA || rd_tag[7:4] !== 4'd8)
      begin n_err++; $display("FAIL ren_beats_cmt r9: got busy=%b data=%h tag=%0d want 1/a/8", rd_busy[1], rd_data[63:32], rd_tag[7:4]); end
    set_ren(3, 1); tick(); clr_in();
    set_cmt(0, 3, 9, 32'h1); set_cmt(1, 3, 1, 32'h2); tick(); clr_in();
    rd_idx = {5'd3, 5'd3}; #1;
    n_cmp++; if (rd_data[31:0] !== 32'h2 || rd_busy[0] !== 1'b0)
      begin n_err++; $display("FAIL dual_cmt p1 match: got data=%h busy=%b want 2/0", rd_data[31:0], rd_busy[0]); end
    set_ren(3, 1); tick(); clr_in();
    set_cmt(0, 3, 1, 32'h3); set_cmt(1, 3, 9, 32'h4); tick(); clr_in();
    n_cmp++; if (rd_data[31:0] !== 32'h4 || rd_busy[0] !== 1'b0)
      begin n_err++; $display("FAIL dual_cmt p0 match: got data=%h busy=%b want 4/0", rd_data[31:0], rd_busy[0]); end
    n_cmp++; if (busy_cnt !== 6'd2) begin n_err++; $display("FAIL same_cycle_cnt: got %0d want 2", busy_cnt); end
  endtask

  task automatic test_rollback();
    clr_in(); set_ren(1, 1); tick(); set_ren(2, 2); tick(); set_ren(3, 3); tick(); clr_in();
    n_cmp++; if (busy_cnt !== 6'd5) begin n_err++; $display("FAIL pre_rollback_cnt: got %0d want 5", busy_cnt); end
    rollback = 1'b1; set_ren(4, 4); set_cmt(0, 2, 2, 32'h55); tick(); clr_in();
    rd_idx = {5'd4, 5'd2}; #1;
    n_cmp++; if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h55 || rd_tag !== 8'h0)
      begin n_err++; $display("FAIL rollback: got busy=%b data=%h tag=%h want 00/55/00", rd_busy, rd_data[31:0], rd_tag); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL rollback_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_reg_zero();
    clr_in(); set_ren(0, 5); set_cmt(0, 0, 0, 32'hFF); set_cmt(1, 0, 5, 32'hEE); tick(); clr_in();
    rd_idx = {5'd0, 5'd0}; #1;
    n_cmp++; if (rd_busy !== 2'b00 || rd_data !== 64'h0 || rd_tag !== 8'h0)
      begin n_err++; $display("FAIL r0: got busy=%b data=%h tag=%h want zeros", rd_busy, rd_data, rd_tag); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL r0_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_rdy_low();
    clr_in(); rdy = 1'b0; set_ren(6, 1); set_cmt(0, 6, 0, 32'h99); tick(); clr_in(); rdy = 1'b1;
    rd_idx = {5'd0, 5'd6}; #1;
    n_cmp++; if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h0)
      begin n_err++; $display("FAIL rdy_low: got busy=%b data=%h want 0/0", rd_busy[0], rd_data[31:0]); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL rdy_low_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_bypass();
    clr_in(); set_ren(10, 5); tick(); clr_in();
    rd_idx = {5'd0, 5'd10}; set_cmt(1, 10, 5, 32'h77); #1;
`ifdef RF_CMT_BYPASS_EN
    n_cmp++; if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h77 || rd_tag[3:0] !== 4'd0)
      begin n_err++; $display("FAIL bypass: got busy=%b data=%h tag=%0d want 0/77/0", rd_busy[0], rd_data[31:0], rd_tag[3:0]); end
`else
    n_cmp++; if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h0 || rd_tag[3:0] !== 4'd5)
      begin n_err++; $display("FAIL no_bypass: got busy=%b data=%h tag=%0d want 1/0/5", rd_busy[0], rd_data[31:0], rd_tag[3:0]); end
`endif
    tick(); clr_in();
    n_cmp++; if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h77)
      begin n_err++; $display("FAIL post_bypass: got busy=%b data=%h want 0/77", rd_busy[0], rd_data[31:0]); end
  endtask

  task automatic test_random();
    logic        eb;
    logic [31:0] ed;
    logic [3:0]  et;
    logic [4:0]  r;
    rst = 1'b1; model_reset(); #2; rst = 1'b0; clr_in(); @(posedge clk); #1;
    for (int i = 0; i < 500; i++) begin
      rdy       = ($urandom_range(9) != 0);
      rollback  = ($urandom_range(24) == 0);
      ren_valid = ($urandom_range(3) != 0);
      ren_rd    = 5'($urandom_range(7));
      ren_tag   = 4'($urandom);
      for (int k = 0; k < 2; k++) begin
        r = 5'($urandom_range(7));
        cmt_valid[k]       = ($urandom_range(2) != 0);
        cmt_rd[k*5 +: 5]   = r;
        cmt_tag[k*4 +: 4]  = ($urandom_range(3) != 0) ? m_tag[r] : 4'($urandom);
        cmt_data[k*32 +: 32] = $urandom;
      end
      rd_idx[4:0] = 5'($urandom_range(7));
      rd_idx[9:5] = 5'($urandom_range(7));
      #1;
      for (int p = 0; p < 2; p++) begin
        exp_read(rd_idx[p*5 +: 5], eb, ed, et);
        n_cmp++;
        if (rd_busy[p] !== eb || rd_data[p*32 +: 32] !== ed || rd_tag[p*4 +: 4] !== et) begin
          n_err++;
          $display("FAIL rand_read i=%0d p=%0d r=%0d: got %b/%h/%0d want %b/%h/%0d", i, p,
                   rd_idx[p*5 +: 5], rd_busy[p], rd_data[p*32 +: 32], rd_tag[p*4 +: 4], eb, ed, et);
        end
      end
      tick();
      n_cmp++;
      if (busy_cnt !== 6'(model_count())) begin
        n_err++; $display("FAIL rand_cnt i=%0d: got %0d want %0d", i, busy_cnt, model_count());
      end
    end
    rdy = 1'b1; clr_in();
  endtask

  task automatic test_rst_mid();
    clr_in(); set_ren(12, 3); set_cmt(0, 13, 0, 32'h1234); tick();
    set_ren(13, 7); set_cmt(0, 12, 3, 32'hCAFE); set_cmt(1, 14, 1, 32'hBEEF);
    rd_idx = {5'd13, 5'd12};
    #2; rst = 1'b1; model_reset(); #1;
    n_cmp++; if (rd_busy !== 2'b00 || rd_data !== 64'h0 || rd_tag !== 8'h0 || busy_cnt !== 6'd0)
      begin n_err++; $display("FAIL rst_async: got busy=%b data=%h tag=%h cnt=%0d want zeros", rd_busy, rd_data, rd_tag, busy_cnt); end
    tick();
    n_cmp++; if (rd_busy !== 2'b00 || rd_data !== 64'h0 || busy_cnt !== 6'd0)
      begin n_err++; $display("FAIL rst_held: got busy=%b data=%h cnt=%0d want zeros", rd_busy, rd_data, busy_cnt); end
    rst = 1'b0; clr_in();
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_rollback();
    test_reg_zero();
    test_rdy_low();
    test_bypass();
    test_random();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
